// File: rtl/p405s_ldstdvcctl.sv
// Load/store data-value-compare controller: registers per-access byte-lane enables,
// qualifies the external byte-compare results and raises a debug event with req/ack.
module p405s_ldstdvcctl (
  input  logic       CB,
  input  logic       resetN,
  input  logic       PCL_agenValid,
  input  logic [1:0] PCL_agenEA,
  input  logic [1:0] PCL_agenSize,
  input  logic       PCL_exeHold,
  input  logic       PCL_exeFlush,
  input  logic [1:0] DBCR_dvc1Mode,
  input  logic [1:0] DBCR_dvc2Mode,
  input  logic [3:0] DBCR_dvc1Be,
  input  logic [3:0] DBCR_dvc2Be,
  input  logic       EXE_dac1Hit,
  input  logic       EXE_dac2Hit,
  input  logic [3:0] EXE_dvc1ByteCmp,
  input  logic [3:0] EXE_dvc2ByteCmp,
  input  logic       DBG_dvcAck,
  output logic [3:0] PCL_dvcByteEnL2,
  output logic       DVC_evtReq,
  output logic [1:0] DVC_evtCode,
  output logic       DVC_evtOvf
);

  // Lane vectors are written big-endian: the leftmost literal bit is byte 0.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_OR  = 2'b10;
  localparam logic [1:0] MODE_AO  = 2'b11;

  function automatic logic qualify(input logic [1:0] mode,
                                   input logic [3:0] en,
                                   input logic [3:0] cmp);
    logic [3:0] c;
    logic       q;
    c = cmp & en;
    q = 1'b0;
    if (en != 4'b0000) begin
      case (mode)
        MODE_AND: q = (c == en);
        MODE_OR:  q = (c != 4'b0000);
        MODE_AO:  q = ((en[3:2] != 2'b00) && (c[3:2] == en[3:2])) ||
                      ((en[1:0] != 2'b00) && (c[1:0] == en[1:0]));
        MODE_OFF: q = 1'b0;
        default:  q = 1'b0;
      endcase
    end
    return q;
  endfunction

  logic [3:0] lanes_p0;
  logic       valid_p1;
  logic [3:0] lanes_p1;
  logic       live_p1;
  logic       hit1_p1;
  logic       hit2_p1;
  logic [1:0] hits_p1;
  logic [0:0] state_p2;
  logic [1:0] code_p2;
  logic       ovf_p2;

  // AGEN: lane decode; only the first word of a crossing access is covered.
  always_comb begin
    lanes_p0 = 4'b0000;
    if (PCL_agenValid) begin
      case (PCL_agenSize)
        2'b00:   lanes_p0 = 4'b1000 >> PCL_agenEA;
        2'b01:   lanes_p0 = 4'b1100 >> PCL_agenEA;
        2'b10:   lanes_p0 = 4'b1111 >> PCL_agenEA;
        default: lanes_p0 = 4'b0000;
      endcase
    end
  end

  // EXE register: flush wins over hold.
  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      valid_p1 <= 1'b0;
      lanes_p1 <= 4'b0000;
    end else if (PCL_exeFlush) begin
      valid_p1 <= 1'b0;
      lanes_p1 <= 4'b0000;
    end else if (!PCL_exeHold) begin
      valid_p1 <= PCL_agenValid;
      lanes_p1 <= lanes_p0;
    end
  end

  assign PCL_dvcByteEnL2 = lanes_p1;

  // EXE: an access is evaluated only in its first non-held, non-flushed cycle.
  assign live_p1 = valid_p1 & ~PCL_exeHold & ~PCL_exeFlush;
  assign hit1_p1 = live_p1 & EXE_dac1Hit &
                   qualify(DBCR_dvc1Mode, DBCR_dvc1Be & lanes_p1, EXE_dvc1ByteCmp);
  assign hit2_p1 = live_p1 & EXE_dac2Hit &
                   qualify(DBCR_dvc2Mode, DBCR_dvc2Be & lanes_p1, EXE_dvc2ByteCmp);
  assign hits_p1 = {hit2_p1, hit1_p1};

  // Event register: hits arriving with an ack start a fresh event rather than being lost.
  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      state_p2 <= IDLE;
      code_p2  <= 2'b00;
      ovf_p2   <= 1'b0;
    end else begin
      case (state_p2)
        IDLE: begin
          if (hits_p1 != 2'b00) begin
            state_p2 <= PEND;
            code_p2  <= hits_p1;
            ovf_p2   <= 1'b0;
          end
        end
        PEND: begin
          if (DBG_dvcAck) begin
            ovf_p2  <= 1'b0;
            code_p2 <= hits_p1;
            if (hits_p1 == 2'b00) begin
              state_p2 <= IDLE;
            end
          end else if (hits_p1 != 2'b00) begin
            code_p2 <= code_p2 | hits_p1;
            ovf_p2  <= 1'b1;
          end
        end
        default: begin
          state_p2 <= IDLE;
          code_p2  <= 2'b00;
          ovf_p2   <= 1'b0;
        end
      endcase
    end
  end

  assign DVC_evtReq  = (state_p2 == PEND);
  assign DVC_evtCode = code_p2;
  assign DVC_evtOvf  = ovf_p2;

endmodule

// File: tb/tb_p405s_ldstdvcctl.sv
// Bench for p405s_ldstdvcctl: directed scenarios plus randomized traffic against a
// byte-level reference model of lane decode, compare qualification and event handshake.
module tb_p405s_ldstdvcctl;

  logic       CB = 1'b0;
  logic       resetN;
  logic       PCL_agenValid;
  logic [1:0] PCL_agenEA;
  logic [1:0] PCL_agenSize;
  logic       PCL_exeHold;
  logic       PCL_exeFlush;
  logic [1:0] DBCR_dvc1Mode;
  logic [1:0] DBCR_dvc2Mode;
  logic [3:0] DBCR_dvc1Be;
  logic [3:0] DBCR_dvc2Be;
  logic       EXE_dac1Hit;
  logic       EXE_dac2Hit;
  logic [3:0] EXE_dvc1ByteCmp;
  logic [3:0] EXE_dvc2ByteCmp;
  logic       DBG_dvcAck;
  logic [3:0] PCL_dvcByteEnL2;
  logic       DVC_evtReq;
  logic [1:0] DVC_evtCode;
  logic       DVC_evtOvf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic       m_valid;
  logic [3:0] m_lanes;
  logic       m_req;
  logic [1:0] m_code;
  logic       m_ovf;

  always #5 CB = ~CB;

  p405s_ldstdvcctl dut (
    .CB(CB), .resetN(resetN),
    .PCL_agenValid(PCL_agenValid), .PCL_agenEA(PCL_agenEA), .PCL_agenSize(PCL_agenSize),
    .PCL_exeHold(PCL_exeHold), .PCL_exeFlush(PCL_exeFlush),
    .DBCR_dvc1Mode(DBCR_dvc1Mode), .DBCR_dvc2Mode(DBCR_dvc2Mode),
    .DBCR_dvc1Be(DBCR_dvc1Be), .DBCR_dvc2Be(DBCR_dvc2Be),
    .EXE_dac1Hit(EXE_dac1Hit), .EXE_dac2Hit(EXE_dac2Hit),
    .EXE_dvc1ByteCmp(EXE_dvc1ByteCmp), .EXE_dvc2ByteCmp(EXE_dvc2ByteCmp),
    .DBG_dvcAck(DBG_dvcAck),
    .PCL_dvcByteEnL2(PCL_dvcByteEnL2), .DVC_evtReq(DVC_evtReq),
    .DVC_evtCode(DVC_evtCode), .DVC_evtOvf(DVC_evtOvf)
  );

  // Byte k of the word is vector bit 3-k (leftmost literal bit is byte 0).
  function automatic logic [3:0] ref_lanes(input logic v, input logic [1:0] ea, input logic [1:0] sz);
    logic [3:0] r;
    int nbytes;
    r = 4'b0000;
    if (!v || sz == 2'b11) return r;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < 4; k++)
      if (k >= int'(ea) && k < int'(ea) + nbytes) r[3-k] = 1'b1;
    return r;
  endfunction

  function automatic logic ref_match(input logic [1:0] mode, input logic [3:0] be,
                                     input logic [3:0] lanes, input logic [3:0] cmp);
    int en_cnt;
    int eq_cnt;
    en_cnt = 0;
    eq_cnt = 0;
    if (mode == 2'b00) return 1'b0;
    for (int k = 0; k < 4; k++)
      if (be[3-k] && lanes[3-k]) begin
        en_cnt++;
        if (cmp[3-k]) eq_cnt++;
      end
    if (en_cnt == 0) return 1'b0;
    if (mode == 2'b01) return eq_cnt == en_cnt;
    if (mode == 2'b10) return eq_cnt > 0;
    for (int h = 0; h < 2; h++) begin
      int he;
      int hq;
      he = 0;
      hq = 0;
      for (int k = 2*h; k < 2*h+2; k++)
        if (be[3-k] && lanes[3-k]) begin
          he++;
          if (cmp[3-k]) hq++;
        end
      if (he > 0 && hq == he) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_lanes = 4'b0000;
    m_req   = 1'b0;
    m_code  = 2'b00;
    m_ovf   = 1'b0;
  endfunction

  // Advance model by one edge using current inputs, then move DUT past that edge.
  task automatic step();
    logic h1;
    logic h2;
    logic [1:0] nc;
    if (!resetN) begin
      model_reset();
    end else begin
      h1 = m_valid && !PCL_exeHold && !PCL_exeFlush && EXE_dac1Hit &&
           ref_match(DBCR_dvc1Mode, DBCR_dvc1Be, m_lanes, EXE_dvc1ByteCmp);
      h2 = m_valid && !PCL_exeHold && !PCL_exeFlush && EXE_dac2Hit &&
           ref_match(DBCR_dvc2Mode, DBCR_dvc2Be, m_lanes, EXE_dvc2ByteCmp);
      nc = {h2, h1};
      if (!m_req) begin
        if (nc != 2'b00) begin
          m_req = 1'b1; m_code = nc; m_ovf = 1'b0;
        end
      end else if (DBG_dvcAck) begin
        m_ovf = 1'b0;
        m_code = nc;
        if (nc == 2'b00) m_req = 1'b0;
      end else if (nc != 2'b00) begin
        m_code = m_code | nc;
        m_ovf = 1'b1;
      end
      if (PCL_exeFlush) begin
        m_valid = 1'b0; m_lanes = 4'b0000;
      end else if (!PCL_exeHold) begin
        m_valid = PCL_agenValid;
        m_lanes = ref_lanes(PCL_agenValid, PCL_agenEA, PCL_agenSize);
      end
    end
    @(posedge CB);
    #1;
  endtask

  task automatic quiet();
    PCL_agenValid = 0; PCL_agenEA = 0; PCL_agenSize = 0;
    PCL_exeHold = 0; PCL_exeFlush = 0;
    EXE_dac1Hit = 0; EXE_dac2Hit = 0;
    EXE_dvc1ByteCmp = 0; EXE_dvc2ByteCmp = 0; DBG_dvcAck = 0;
  endtask

  // Access in AGEN, then present compare results in EXE; returns lanes seen in EXE.
  task automatic evaluate(input logic [1:0] ea, input logic [1:0] sz,
                          input logic d1, input logic [3:0] c1,
                          input logic d2, input logic [3:0] c2,
                          input logic ack, output logic [3:0] lanes);
    PCL_agenValid = 1; PCL_agenEA = ea; PCL_agenSize = sz;
    step();
    lanes = PCL_dvcByteEnL2;
    PCL_agenValid = 0;
    EXE_dac1Hit = d1; EXE_dvc1ByteCmp = c1;
    EXE_dac2Hit = d2; EXE_dvc2ByteCmp = c2;
    DBG_dvcAck = ack;
    step();
    quiet();
  endtask

  task automatic clear_event();
    DBG_dvcAck = 1;
    step();
    DBG_dvcAck = 0;
  endtask

  task automatic test_reset();
    quiet();
    DBCR_dvc1Mode = 0; DBCR_dvc2Mode = 0; DBCR_dvc1Be = 0; DBCR_dvc2Be = 0;
    resetN = 1;
    #1 resetN = 0;
    model_reset();
    step();
    step();
    tests++; if (PCL_dvcByteEnL2 !== 4'b0000) begin fails++; $display("FAIL reset_lanes: got %b exp 0000", PCL_dvcByteEnL2); end
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", DVC_evtReq); end
    tests++; if (DVC_evtCode !== 2'b00) begin fails++; $display("FAIL reset_code: got %b exp 00", DVC_evtCode); end
    tests++; if (DVC_evtOvf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b exp 0", DVC_evtOvf); end
    resetN = 1;
  endtask

  task automatic test_word_and();
    logic [3:0] ln;
    DBCR_dvc1Mode = 2'b01; DBCR_dvc1Be = 4'b1111;
    DBCR_dvc2Mode = 2'b00; DBCR_dvc2Be = 4'b0000;
    evaluate(2'd0, 2'b10, 1, 4'b1111, 0, 4'b0000, 0, ln);
    tests++; if (ln !== 4'b1111) begin fails++; $display("FAIL word_lanes: got %b exp 1111", ln); end
    tests++; if (DVC_evtReq !== 1'b1) begin fails++; $display("FAIL word_and_req: got %b exp 1", DVC_evtReq); end
    tests++; if (DVC_evtCode !== 2'b01) begin fails++; $display("FAIL word_and_code: got %b exp 01", DVC_evtCode); end
    clear_event();
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL ack_clear_req: got %b exp 0", DVC_evtReq); end
    evaluate(2'd0, 2'b10, 1, 4'b1110, 0, 4'b0000, 0, ln);
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL word_and_miss: got %b exp 0", DVC_evtReq); end
  endtask

  task automatic test_half_or();
    logic [3:0] ln;
    DBCR_dvc1Mode = 2'b00; DBCR_dvc1Be = 4'b0000;
    DBCR_dvc2Mode = 2'b10; DBCR_dvc2Be = 4'b1111;
    evaluate(2'd1, 2'b01, 0, 4'b0000, 1, 4'b0010, 0, ln);
    tests++; if (ln !== 4'b0110) begin fails++; $display("FAIL half_lanes: got %b exp 0110", ln); end
    tests++; if (DVC_evtCode !== 2'b10 || DVC_evtReq !== 1'b1) begin fails++; $display("FAIL half_or_hit: got req %b code %b exp req 1 code 10", DVC_evtReq, DVC_evtCode); end
    clear_event();
    evaluate(2'd1, 2'b01, 0, 4'b0000, 0, 4'b0010, 0, ln);
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL half_no_dac: got %b exp 0", DVC_evtReq); end
    evaluate(2'd2, 2'b00, 0, 4'b0000, 0, 4'b0000, 0, ln);
    tests++; if (ln !== 4'b0010) begin fails++; $display("FAIL byte_lanes: got %b exp 0010", ln); end
    evaluate(2'd1, 2'b11, 0, 4'b0000, 0, 4'b0000, 0, ln);
    tests++; if (ln !== 4'b0000) begin fails++; $display("FAIL rsvd_lanes: got %b exp 0000", ln); end
  endtask

  task automatic test_and_or();
    logic [3:0] ln;
    DBCR_dvc1Mode = 2'b11; DBCR_dvc1Be = 4'b1111;
    DBCR_dvc2Mode = 2'b00; DBCR_dvc2Be = 4'b0000;
    evaluate(2'd0, 2'b10, 1, 4'b0011, 0, 4'b0000, 0, ln);
    tests++; if (DVC_evtReq !== 1'b1 || DVC_evtCode !== 2'b01) begin fails++; $display("FAIL ao_hit: got req %b code %b exp req 1 code 01", DVC_evtReq, DVC_evtCode); end
    clear_event();
    evaluate(2'd0, 2'b10, 1, 4'b0101, 0, 4'b0000, 0, ln);
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL ao_split: got %b exp 0", DVC_evtReq); end
    DBCR_dvc1Be = 4'b1100;
    evaluate(2'd0, 2'b10, 1, 4'b0011, 0, 4'b0000, 0, ln);
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL ao_masked: got %b exp 0", DVC_evtReq); end
  endtask

  task automatic test_hold_flush();
    DBCR_dvc1Mode = 2'b01; DBCR_dvc1Be = 4'b1111;
    PCL_agenValid = 1; PCL_agenEA = 0; PCL_agenSize = 2'b10;
    step();
    PCL_agenValid = 0;
    EXE_dac1Hit = 1; EXE_dvc1ByteCmp = 4'b1111;
    PCL_exeHold = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (DVC_evtReq !== 1'b0 || PCL_dvcByteEnL2 !== 4'b1111) begin fails++; $display("FAIL hold_cycle%0d: got req %b lanes %b exp req 0 lanes 1111", i, DVC_evtReq, PCL_dvcByteEnL2); end
    end
    PCL_exeHold = 0;
    step();
    tests++; if (DVC_evtReq !== 1'b1 || DVC_evtCode !== 2'b01) begin fails++; $display("FAIL hold_release: got req %b code %b exp req 1 code 01", DVC_evtReq, DVC_evtCode); end
    step();
    tests++; if (DVC_evtCode !== 2'b01 || DVC_evtOvf !== 1'b0) begin fails++; $display("FAIL hold_once: got code %b ovf %b exp code 01 ovf 0", DVC_evtCode, DVC_evtOvf); end
    quiet();
    clear_event();
    PCL_agenValid = 1; PCL_agenEA = 0; PCL_agenSize = 2'b10;
    step();
    PCL_agenValid = 0;
    EXE_dac1Hit = 1; EXE_dvc1ByteCmp = 4'b1111; PCL_exeFlush = 1;
    step();
    tests++; if (PCL_dvcByteEnL2 !== 4'b0000 || DVC_evtReq !== 1'b0) begin fails++; $display("FAIL flush: got lanes %b req %b exp lanes 0000 req 0", PCL_dvcByteEnL2, DVC_evtReq); end
    PCL_exeFlush = 0;
    step();
    tests++; if (DVC_evtReq !== 1'b0) begin fails++; $display("FAIL flush_after: got %b exp 0", DVC_evtReq); end
    quiet();
  endtask

  task automatic test_merge();
    logic [3:0] ln;
    DBCR_dvc1Mode = 2'b01; DBCR_dvc1Be = 4'b1111;
    DBCR_dvc2Mode = 2'b01; DBCR_dvc2Be = 4'b1111;
    evaluate(2'd0, 2'b10, 1, 4'b1111, 0, 4'b0000, 0, ln);
    evaluate(2'd0, 2'b10, 0, 4'b0000, 1, 4'b1111, 0, ln);
    tests++; if (DVC_evtCode !== 2'b11 || DVC_evtOvf !== 1'b1) begin fails++; $display("FAIL merge: got code %b ovf %b exp code 11 ovf 1", DVC_evtCode, DVC_evtOvf); end
    evaluate(2'd0, 2'b10, 1, 4'b1111, 0, 4'b0000, 1, ln);
    tests++; if (DVC_evtReq !== 1'b1 || DVC_evtCode !== 2'b01 || DVC_evtOvf !== 1'b0) begin fails++; $display("FAIL ack_with_hit: got req %b code %b ovf %b exp 1 01 0", DVC_evtReq, DVC_evtCode, DVC_evtOvf); end
    clear_event();
  endtask

  task automatic test_back_to_back();
    DBCR_dvc1Mode = 2'b01; DBCR_dvc1Be = 4'b1111;
    DBCR_dvc2Mode = 2'b10; DBCR_dvc2Be = 4'b0001;
    PCL_agenValid = 1; PCL_agenEA = 0; PCL_agenSize = 2'b10;
    step();
    PCL_agenEA = 3; PCL_agenSize = 2'b00;
    EXE_dac1Hit = 1; EXE_dvc1ByteCmp = 4'b1111;
    step();
    PCL_agenValid = 0;
    tests++; if (PCL_dvcByteEnL2 !== 4'b0001 || DVC_evtCode !== 2'b01) begin fails++; $display("FAIL b2b_first: got lanes %b code %b exp 0001 01", PCL_dvcByteEnL2, DVC_evtCode); end
    EXE_dac1Hit = 0; EXE_dac2Hit = 1; EXE_dvc2ByteCmp = 4'b0001; DBG_dvcAck = 1;
    step();
    tests++; if (DVC_evtReq !== 1'b1 || DVC_evtCode !== 2'b10 || DVC_evtOvf !== 1'b0) begin fails++; $display("FAIL b2b_second: got req %b code %b ovf %b exp 1 10 0", DVC_evtReq, DVC_evtCode, DVC_evtOvf); end
    quiet();
    clear_event();
  endtask

  task automatic test_async_reset();
    logic [3:0] ln;
    DBCR_dvc1Mode = 2'b01; DBCR_dvc1Be = 4'b1111;
    evaluate(2'd0, 2'b10, 1, 4'b1111, 0, 4'b0000, 0, ln);
    PCL_agenValid = 1; PCL_agenSize = 2'b10;
    #2 resetN = 0;
    #1;
    model_reset();
    tests++; if (DVC_evtReq !== 1'b0 || DVC_evtCode !== 2'b00 || DVC_evtOvf !== 1'b0 || PCL_dvcByteEnL2 !== 4'b0000) begin fails++; $display("FAIL async_reset: got req %b code %b ovf %b lanes %b exp all 0", DVC_evtReq, DVC_evtCode, DVC_evtOvf, PCL_dvcByteEnL2); end
    step();
    resetN = 1;
    quiet();
    evaluate(2'd0, 2'b10, 1, 4'b1111, 0, 4'b0000, 0, ln);
    tests++; if (ln !== 4'b1111 || DVC_evtReq !== 1'b1 || DVC_evtCode !== 2'b01) begin fails++; $display("FAIL post_reset: got lanes %b req %b code %b exp 1111 1 01", ln, DVC_evtReq, DVC_evtCode); end
    clear_event();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      PCL_agenValid   = ($urandom_range(0, 3) != 0);
      PCL_agenEA      = 2'($urandom_range(0, 3));
      PCL_agenSize    = 2'($urandom_range(0, 3));
      PCL_exeHold     = ($urandom_range(0, 7) == 0);
      PCL_exeFlush    = ($urandom_range(0, 11) == 0);
      EXE_dac1Hit     = ($urandom_range(0, 3) != 0);
      EXE_dac2Hit     = ($urandom_range(0, 3) != 0);
      EXE_dvc1ByteCmp = 4'($urandom_range(0, 15));
      EXE_dvc2ByteCmp = 4'($urandom_range(0, 15));
      DBG_dvcAck      = ($urandom_range(0, 2) == 0);
      if (i % 40 == 0) begin
        DBCR_dvc1Mode = 2'($urandom_range(0, 3));
        DBCR_dvc2Mode = 2'($urandom_range(0, 3));
        DBCR_dvc1Be   = 4'($urandom_range(0, 15));
        DBCR_dvc2Be   = 4'($urandom_range(0, 15));
      end
      step();
      tests++; if (PCL_dvcByteEnL2 !== m_lanes) begin fails++; $display("FAIL rnd_lanes[%0d]: got %b exp %b", i, PCL_dvcByteEnL2, m_lanes); end
      tests++; if (DVC_evtReq !== m_req) begin fails++; $display("FAIL rnd_req[%0d]: got %b exp %b", i, DVC_evtReq, m_req); end
      tests++; if (DVC_evtCode !== m_code) begin fails++; $display("FAIL rnd_code[%0d]: got %b exp %b", i, DVC_evtCode, m_code); end
      tests++; if (DVC_evtOvf !== m_ovf) begin fails++; $display("FAIL rnd_ovf[%0d]: got %b exp %b", i, DVC_evtOvf, m_ovf); end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_word_and();
    test_half_or();
    test_and_or();
    test_hold_flush();
    test_merge();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p405s_ldstdvcctl.md
# p405s_ldStDvcCtl

Controller for the load/store data value compare (DVC) datapath. It registers the per-access byte-lane enables that gate the byte comparators and qualifies the raw per-byte compare results with the debug-control DVC mode, byte mask and DAC address hits. It then raises a debug event to the debug unit through a request/acknowledge handshake. The block sits between the load/store pipeline control (AGEN→EXE) and the debug unit; the byte comparators themselves are external.

## Interface
- No parameters.
- CB  in  1  core clock; all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- PCL_agenValid  in  1  load/store access in AGEN this cycle.
- PCL_agenEA  in  2  effective address bits 30:31 of the AGEN access.
- PCL_agenSize  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (no lanes).
- PCL_exeHold  in  1  EXE stalled; EXE-stage state frozen.
- PCL_exeFlush  in  1  kill the access in EXE; no event from it.
- DBCR_dvc1Mode, DBCR_dvc2Mode  in  2 each  00 off, 01 AND, 10 OR, 11 AND-OR (halfword).
- DBCR_dvc1Be, DBCR_dvc2Be  in  4 each  byte-enable mask per compare.
- EXE_dac1Hit, EXE_dac2Hit  in  1 each  address compare hit for the EXE access.
- EXE_dvc1ByteCmp, EXE_dvc2ByteCmp  in  4 each  lane-gated byte equality from the comparators.
- DBG_dvcAck  in  1  debug unit accepts the pending event.
- PCL_dvcByteEnL2  out  4  registered lane enables to the comparators (bit 0 = byte 0, MSB lane).
- DVC_evtReq  out  1  event pending.
- DVC_evtCode  out  2  bit 0 = DVC1 hit, bit 1 = DVC2 hit; valid while DVC_evtReq.
- DVC_evtOvf  out  1  sticky: an event merged into an already-pending event; cleared by ack.

## Operation
- Lane decode (AGEN, combinational):
  - byte: one-hot at EA (EA=2 → 0010).
  - half: EA 0→1100, 1→0110, 2→0011, 3→0001.
  - word: EA 0→1111, 1→0111, 2→0011, 3→0001.
  - Size 11 or !PCL_agenValid → 0000.
  - Only the first word of a crossing access is compared.
- EXE register: {valid, lanes} loads the AGEN values when !PCL_exeHold. It holds during a hold. PCL_exeFlush clears valid and lanes to 0 at the next edge, and flush takes priority over hold. PCL_dvcByteEnL2 = the registered lanes.
- Qualification per compare n, with E = DBCR_dvcnBe & PCL_dvcByteEnL2 and C = EXE_dvcnByteCmp & E:
  - mode 00 or E==0000 → no hit.
  - AND: C==E.
  - OR: C!=0.
  - AO: (E[0:1]!=0 & C[0:1]==E[0:1]) | (E[2:3]!=0 & C[2:3]==E[2:3]).
  - hit_n = qualified & EXE_dacnHit & valid & !PCL_exeHold & !PCL_exeFlush.
- Event FSM, IDLE / PEND:
  - IDLE: any hit → PEND with code = {hit2, hit1}.
  - PEND, no ack: new hits OR into the code; DVC_evtOvf sets if any new hit occurs.
  - PEND with ack and no new hit → IDLE, code 00, Ovf 0.
  - PEND with ack and a simultaneous new hit → stay PEND with code = new hits only, Ovf 0. The event is not lost.
  - Ack in IDLE is ignored.
- Reset values: EXE valid 0, PCL_dvcByteEnL2 0000, state IDLE, DVC_evtReq 0, DVC_evtCode 00, DVC_evtOvf 0. Reset mid-PEND drops the event.

## Timing
- Access in AGEN at cycle n → PCL_dvcByteEnL2 valid in cycle n+1, with no hold.
- Comparator results and DAC hits are sampled in cycle n+1. DVC_evtReq/DVC_evtCode are registered and assert in cycle n+2.
- Each EXE hold cycle delays evaluation by one cycle. An access is evaluated exactly once: in its first non-held EXE cycle.
- Ack is sampled on an edge where DVC_evtReq=1. DVC_evtReq falls in the following cycle unless a new hit arrived.
- Back-to-back accesses produce one evaluation per cycle. No bubble is required.

## Test plan
- Word store, EA=0: Be1=1111, mode AND, dac1Hit=1, cmp1=1111 → ByteEnL2=1111 at n+1; evtReq=1, code=01 at n+2. With cmp1=1110 → no event.
- Halfword, EA=1: lanes 0110, Be2=1111, mode OR, dac2Hit=1, cmp2=0010 → code=10. Same with dac2Hit=0 → no event.
- AO mode: Be1=1111, word access, cmp1=0011 → hit. cmp1=0101 → no hit. Be1=1100 with cmp1=0011 → no hit.
- Hold 3 cycles in EXE with a matching access → exactly one event, 3 cycles later than nominal. Flush in the same EXE cycle → no event, ByteEnL2=0000 next cycle.
- Hit1 pending without ack, then hit2 → code=11, Ovf=1. Ack together with a new hit1 → evtReq stays 1, code=01, Ovf=0.
- Assert resetN low while PEND → all outputs return to reset values immediately (asynchronous). After release, first access behaves as nominal.
